// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with valid/ready holding register and frame/parity/overrun status.
// Optional parity stage is compiled in by defining UART_RX_PARITY_EN.
module uart_rx_cfg #(
   parameter int DBIT    = 8,
   parameter int OVS     = 16,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            rx,
   input  logic            s_tick,
   input  logic            par_odd,
   input  logic            rx_ready,
   output logic            rx_valid,
   output logic [DBIT-1:0] rx_dout,
   output logic            frame_err,
   output logic            parity_err,
   output logic            overrun_err,
   output logic            rx_done_tick
);

   localparam int TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
   localparam int TW   = $clog2(TMAX);
   localparam int BW   = $clog2(DBIT);
   localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] T_BIT  = TW'(OVS - 1);
   localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4} state_t;
`endif

   function automatic logic xor_reduce(input logic [DBIT-1:0] d);
      return ^d;
   endfunction

   state_t          state_r, state_nxt_s;
   logic [TW-1:0]   tick_r, tick_nxt_s;
   logic [BW-1:0]   bit_r, bit_nxt_s;
   logic [DBIT-1:0] sh_r, sh_nxt_s;
   logic            sync1_r, rxs_r;
   logic            done_s;
   logic            perr_s;

`ifdef UART_RX_PARITY_EN
   logic par_r, par_nxt_s;
   assign perr_s = ((xor_reduce(sh_r) ^ par_r) != par_odd);
`else
   logic unused_par_odd;
   assign unused_par_odd = par_odd;
   assign perr_s = 1'b0;
`endif

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_r <= 1'b1;
         rxs_r   <= 1'b1;
      end else begin
         sync1_r <= rx;
         rxs_r   <= sync1_r;
      end
   end

   // FSM state, counters and shift register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= IDLE;
         tick_r  <= '0;
         bit_r   <= '0;
         sh_r    <= '0;
`ifdef UART_RX_PARITY_EN
         par_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_nxt_s;
         tick_r  <= tick_nxt_s;
         bit_r   <= bit_nxt_s;
         sh_r    <= sh_nxt_s;
`ifdef UART_RX_PARITY_EN
         par_r   <= par_nxt_s;
`endif
      end
   end

   // Next-state logic; counters move only on s_tick, start detection does not wait for it.
   always_comb begin
      state_nxt_s = state_r;
      tick_nxt_s  = tick_r;
      bit_nxt_s   = bit_r;
      sh_nxt_s    = sh_r;
      done_s      = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_nxt_s   = par_r;
`endif
      case (state_r)
         IDLE: begin
            if (!rxs_r) begin
               tick_nxt_s  = '0;
               state_nxt_s = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (s_tick && (tick_r == T_HALF)) begin
               if (!rxs_r) begin
                  tick_nxt_s  = '0;
                  bit_nxt_s   = '0;
                  state_nxt_s = DATA;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else if (s_tick) begin
               tick_nxt_s = tick_r + 1'b1;
            end else begin
               tick_nxt_s = tick_r;
            end
         end
         DATA: begin
            if (s_tick && (tick_r == T_BIT)) begin
               sh_nxt_s   = {rxs_r, sh_r[DBIT-1:1]};
               tick_nxt_s = '0;
               if (bit_r == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt_s = PARITY;
`else
                  state_nxt_s = STOP;
`endif
               end else begin
                  bit_nxt_s = bit_r + 1'b1;
               end
            end else if (s_tick) begin
               tick_nxt_s = tick_r + 1'b1;
            end else begin
               tick_nxt_s = tick_r;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (s_tick && (tick_r == T_BIT)) begin
               par_nxt_s   = rxs_r;
               tick_nxt_s  = '0;
               state_nxt_s = STOP;
            end else if (s_tick) begin
               tick_nxt_s = tick_r + 1'b1;
            end else begin
               tick_nxt_s = tick_r;
            end
         end
`endif
         STOP: begin
            if (s_tick && (tick_r == T_STOP)) begin
               done_s      = 1'b1;
               state_nxt_s = IDLE;
            end else if (s_tick) begin
               tick_nxt_s = tick_r + 1'b1;
            end else begin
               tick_nxt_s = tick_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Holding register: a completed frame is dropped (and flagged) only if the slot stays occupied.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_done_tick <= 1'b0;
         rx_valid     <= 1'b0;
         rx_dout      <= '0;
         frame_err    <= 1'b0;
         parity_err   <= 1'b0;
         overrun_err  <= 1'b0;
      end else begin
         rx_done_tick <= done_s;
         if (done_s && (!rx_valid || rx_ready)) begin
            rx_dout     <= sh_r;
            frame_err   <= ~rxs_r;
            parity_err  <= perr_s;
            overrun_err <= 1'b0;
            rx_valid    <= 1'b1;
         end else if (done_s) begin
            overrun_err <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
         end
      end
   end

endmodule
